// File: rtl/mic_delay_sum.sv
// mic_delay_sum: delay-and-sum beamformer over per-channel circular history RAM.
// Frames are written, read back at per-channel delays, summed, shifted and saturated.
module mic_delay_sum #(
  parameter int CHANNELS = 6,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      cfg_we,
  input  logic [CW-1:0]             cfg_chan,
  input  logic [AW-1:0]             cfg_delay,
  input  logic                      cfg_gain_we,
  input  logic [3:0]                cfg_gain,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic                      flag_clr,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      busy,
  output logic                      clip,
  output logic                      overrun
);
  localparam int NW = $clog2(CHANNELS + 1);
  localparam int ACW = WIDTH + $clog2(CHANNELS) + 1;
  typedef enum logic [1:0] {IDLE, WRITE, READ, SCALE} state_t;
  state_t state;
  logic [NW-1:0] ch;
  logic [CW-1:0] chi;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [AW-1:0] dly_cfg [CHANNELS];
  logic [AW-1:0] dly_act [CHANNELS];
  logic [3:0] gain_cfg, gain_act;
  logic [CHANNELS-1:0] en_act;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] fill;
  logic [WIDTH-1:0] ram [CHANNELS*DEPTH];
  logic [CW+AW-1:0] ram_addr;
  logic signed [WIDTH-1:0] rd_data;
  logic rd_use, rd_issue, fits;
  logic signed [ACW-1:0] acc, scaled;
  logic [WIDTH-1:0] sat;
  always_comb begin
    chi = ch[CW-1:0];
    busy = state != IDLE;
    rd_issue = state == READ && ch != NW'(CHANNELS);
    ram_addr = {chi, state == WRITE ? wr_ptr : wr_ptr - dly_act[chi]};
    scaled = acc >>> gain_act;
    fits = &scaled[ACW-1:WIDTH-1] | ~|scaled[ACW-1:WIDTH-1];
    sat = fits ? scaled[WIDTH-1:0] : {scaled[ACW-1], {(WIDTH-1){~scaled[ACW-1]}}};
  end
  // History RAM: write phase and read phase never overlap, read data is registered
  always_ff @(posedge ck) begin
    if (state == WRITE && !rst) ram[ram_addr] <= shadow[chi];
    if (rd_issue) rd_data <= ram[ram_addr];
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      clip <= 1'b0;
      overrun <= 1'b0;
      wr_ptr <= '0;
      fill <= '0;
      gain_cfg <= '0;
      acc <= '0;
      rd_use <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) dly_cfg[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (cfg_we && {1'b0, cfg_chan} < (CW+1)'(CHANNELS)) dly_cfg[cfg_chan] <= cfg_delay;
      if (cfg_gain_we) gain_cfg <= cfg_gain;
      overrun <= (overrun & ~flag_clr) | (in_valid & busy);
      clip <= (clip & ~flag_clr) | (state == SCALE && !fits);
      // Unfilled history slots contribute zero, so stale RAM contents never leak out
      rd_use <= en_act[chi] && ({1'b0, dly_act[chi]} <= fill);
      case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < CHANNELS; i++) shadow[i] <= in_data[i*WIDTH +: WIDTH];
          dly_act <= dly_cfg;
          gain_act <= gain_cfg;
          en_act <= chan_en;
          ch <= '0;
          state <= WRITE;
        end
        WRITE: begin
          ch <= (ch == NW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
          acc <= '0;
          if (ch == NW'(CHANNELS - 1)) state <= READ;
        end
        READ: begin
          ch <= ch + 1'b1;
          if (ch != '0) acc <= acc + (rd_use ? ACW'(rd_data) : '0);
          if (!rd_issue) state <= SCALE;
        end
        SCALE: begin
          out_valid <= 1'b1;
          out_data <= sat;
          wr_ptr <= wr_ptr + 1'b1;
          fill <= fill + {{AW{1'b0}}, fill != (AW+1)'(DEPTH)};
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mic_delay_sum.sv
// tb_mic_delay_sum: directed and random frames checked against a frame-history reference model.
module tb_mic_delay_sum;
  logic ck = 1'b0;
  logic rst, in_valid, cfg_we, cfg_gain_we, flag_clr;
  logic [95:0] in_data;
  logic [2:0] cfg_chan;
  logic [7:0] cfg_delay;
  logic [3:0] cfg_gain;
  logic [5:0] chan_en;
  logic out_valid, busy, clip, overrun;
  logic [15:0] out_data;
  int tests = 0;
  int fails = 0;
  int hist[6][$];
  int m_dly[6];
  int m_gain;
  logic [5:0] m_en;
  bit exp_clip;
  mic_delay_sum dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_delay(cfg_delay),
    .cfg_gain_we(cfg_gain_we), .cfg_gain(cfg_gain), .chan_en(chan_en),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .clip(clip), .overrun(overrun)
  );
  always #5 ck = ~ck;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Expected output: sum of enabled channels' sample from d frames ago, shifted, clamped
  function automatic int model_out(output bit s);
    longint acc = 0;
    for (int c = 0; c < 6; c++)
      if (m_en[c] && m_dly[c] < hist[c].size()) acc += hist[c][hist[c].size() - 1 - m_dly[c]];
    acc = acc >>> m_gain;
    s = 1'b0;
    if (acc > 32767) begin acc = 32767; s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    return int'(acc);
  endfunction
  function automatic logic [95:0] pack(input int s[6]);
    logic [95:0] d;
    for (int c = 0; c < 6; c++) d[c*16 +: 16] = 16'(s[c]);
    return d;
  endfunction
  function automatic void model_clear();
    for (int c = 0; c < 6; c++) begin hist[c].delete(); m_dly[c] = 0; end
    m_gain = 0;
    exp_clip = 1'b0;
  endfunction
  task automatic do_reset();
    @(negedge ck); rst = 1'b1;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    model_clear();
  endtask
  task automatic set_delay(input int c, input int d);
    @(negedge ck); cfg_we = 1'b1; cfg_chan = 3'(c); cfg_delay = 8'(d);
    @(negedge ck); cfg_we = 1'b0;
    if (c < 6) m_dly[c] = d;
  endtask
  task automatic set_gain(input int g);
    @(negedge ck); cfg_gain_we = 1'b1; cfg_gain = 4'(g);
    @(negedge ck); cfg_gain_we = 1'b0;
    m_gain = g;
  endtask
  task automatic set_en(input logic [5:0] e);
    chan_en = e;
    m_en = e;
  endtask
  task automatic clear_flags();
    @(negedge ck); flag_clr = 1'b1;
    @(negedge ck); flag_clr = 1'b0;
    exp_clip = 1'b0;
  endtask
  task automatic send_frame(input int s[6], input string tag, output int obs);
    int n, bc, exp;
    bit esat;
    @(negedge ck); in_data = pack(s); in_valid = 1'b1;
    @(posedge ck); #1; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) hist[c].push_back(s[c]);
    exp = model_out(esat);
    exp_clip = exp_clip | esat;
    n = 0;
    bc = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge ck); #1; n++;
    end
    chk({tag, "_lat"}, n, 14);
    chk({tag, "_busy"}, bc, 14);
    chk(tag, $signed(out_data), exp);
    chk({tag, "_clip"}, clip, exp_clip);
    obs = int'($signed(out_data));
  endtask
  initial begin
    int s[6];
    int obs, n, cnt, exp;
    bit esat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_chan = '0; cfg_delay = '0;
    cfg_gain_we = 1'b0; cfg_gain = '0; flag_clr = 1'b0;
    set_en(6'h3f);
    do_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    s = '{100, 100, 100, 100, 100, 100};
    send_frame(s, "sum600", obs);
    chk("sum600_const", obs, 600);
    do_reset();
    set_en(6'b000100);
    set_delay(2, 3);
    for (int k = 1; k <= 5; k++) begin
      for (int c = 0; c < 6; c++) s[c] = int'($signed(16'($urandom)));
      s[2] = k;
      send_frame(s, "dly3", obs);
      chk("dly3_const", obs, (k < 4) ? 0 : k - 3);
    end
    do_reset();
    set_en(6'h3f);
    s = '{32767, 32767, 32767, 32767, 32767, 32767};
    send_frame(s, "sat_g0", obs);
    chk("sat_g0_const", obs, 32767);
    chk("sat_g0_clipset", clip, 1);
    set_gain(3);
    send_frame(s, "sat_g3", obs);
    chk("sat_g3_const", obs, 24575);
    chk("sat_g3_clipheld", clip, 1);
    clear_flags();
    #1;
    chk("clip_cleared", clip, 0);
    s = '{-32768, -32768, -32768, -32768, -32768, -32768};
    set_gain(0);
    send_frame(s, "sat_neg", obs);
    chk("sat_neg_const", obs, -32768);
    set_delay(7, 9);
    set_delay(6, 9);
    s = '{11, 22, 33, 44, 55, 66};
    send_frame(s, "bad_chan", obs);
    chk("bad_chan_const", obs, 231);
    do_reset();
    set_en(6'b000001);
    set_delay(0, 255);
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < 6; c++) s[c] = int'($signed(16'($urandom)));
      s[0] = k;
      send_frame(s, "ramp", obs);
      if (k >= 255) chk("ramp_const", obs, k - 255);
    end
    do_reset();
    set_en(6'h3f);
    for (int c = 0; c < 6; c++) s[c] = int'($urandom_range(0, 8000)) - 4000;
    @(negedge ck); in_data = pack(s); in_valid = 1'b1;
    @(posedge ck); #1; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) hist[c].push_back(s[c]);
    exp = model_out(esat);
    repeat (4) @(posedge ck);
    @(negedge ck);
    in_data = pack('{1000, 2000, 3000, 4000, 5000, 6000}); in_valid = 1'b1;
    cfg_gain_we = 1'b1; cfg_gain = 4'd5;
    @(posedge ck); #1;
    in_valid = 1'b0; cfg_gain_we = 1'b0; m_gain = 5;
    chk("overrun_set", overrun, 1);
    n = 5;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge ck); #1; n++; end
    chk("ovr_lat", n, 14);
    chk("ovr_first_out", $signed(out_data), exp);
    chk("ovr_still_set", overrun, 1);
    clear_flags();
    #1;
    chk("overrun_cleared", overrun, 0);
    set_delay(0, 1);
    for (int c = 0; c < 6; c++) s[c] = int'($urandom_range(0, 8000)) - 4000;
    send_frame(s, "ovr_next", obs);
    @(negedge ck); in_data = pack(s); in_valid = 1'b1;
    @(posedge ck); #1; in_valid = 1'b0;
    repeat (5) @(posedge ck);
    @(negedge ck); rst = 1'b1;
    @(negedge ck); rst = 1'b0;
    model_clear();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ck); #1;
      if (out_valid === 1'b1) cnt++;
    end
    chk("rst_mid_no_out", cnt, 0);
    chk("rst_mid_busy", busy, 0);
    set_en(6'b000001);
    set_delay(0, 1);
    s = '{500, 1, 2, 3, 4, 5};
    send_frame(s, "rst_fill", obs);
    chk("rst_fill_const", obs, 0);
    s = '{-7, 1, 2, 3, 4, 5};
    send_frame(s, "rst_fill2", obs);
    chk("rst_fill2_const", obs, 500);
    clear_flags();
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) begin
        for (int c = 0; c < 6; c++) set_delay(c, $urandom_range(0, 9));
        set_gain($urandom_range(0, 4));
        set_en(6'($urandom));
      end
      for (int c = 0; c < 6; c++) s[c] = int'($signed(16'($urandom)));
      send_frame(s, "rand", obs);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
